// File: rtl/blink_rate_sequencer.sv
// blink_rate_sequencer
// Run/pause controller and four-rate selector for the LED blink divider.
// clock_out toggles every HALF[rate_sel] cycles of clock_in while running.
// Rate requests made while running are queued in pending_sel and only take
// effect at a toggle boundary, so a half-period is never cut short.
// Optional feature macro: BLINK_SEQ_SYNC_EN -- when defined, next and pause
// are treated as asynchronous button levels and pass through a 2-flop
// synchronizer plus rising-edge detector (3 cycles of added latency).
module blink_rate_sequencer #(
    parameter logic [31:0] HALF0 = 32'd10_000_000,
    parameter logic [31:0] HALF1 = 32'd25_000_000,
    parameter logic [31:0] HALF2 = 32'd50_000_000,
    parameter logic [31:0] HALF3 = 32'd100_000_000
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       next,
    input  logic       pause,
    output logic       clock_out,
    output logic       tick,
    output logic [1:0] rate_sel,
    output logic       running
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] count_reg, count_next;
    logic        clock_out_reg, clock_out_next;
    logic        tick_reg, tick_next;
    logic [1:0]  rate_sel_reg, rate_sel_next;
    logic [1:0]  pending_sel_reg, pending_sel_next;

    logic        next_req;
    logic        pause_req;

`ifdef BLINK_SEQ_SYNC_EN
    // Button levels arrive asynchronously: synchronize, then emit one
    // single-cycle request per rising edge of each button.
    logic [1:0] btn_level;
    logic [1:0] btn_req;

    assign btn_level = {pause, next};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic sync1_reg;
            logic sync2_reg;
            logic sync3_reg;
            logic req_reg;

            // Two-flop synchronizer, delayed copy and registered edge pulse.
            always_ff @(posedge clock_in) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    sync3_reg <= 1'b0;
                    req_reg   <= 1'b0;
                end else begin
                    sync1_reg <= btn_level[gi];
                    sync2_reg <= sync1_reg;
                    sync3_reg <= sync2_reg;
                    req_reg   <= sync2_reg & ~sync3_reg;
                end
            end

            assign btn_req[gi] = req_reg;
        end
    endgenerate

    assign next_req  = btn_req[0];
    assign pause_req = btn_req[1];
`else
    assign next_req  = next;
    assign pause_req = pause;
`endif

    // Half-period length, in clock_in cycles, of a given rate.
    function automatic logic [31:0] half_of(input logic [1:0] sel);
        logic [31:0] h;
        case (sel)
            2'd0:    h = HALF0;
            2'd1:    h = HALF1;
            2'd2:    h = HALF2;
            default: h = HALF3;
        endcase
        return h;
    endfunction

    // Terminal count of the rate in effect; exact equality keeps every
    // half-period exactly HALFn cycles and keeps count from ever wrapping.
    logic [31:0] terminal_count;
    logic        at_terminal;

    assign terminal_count = half_of(rate_sel_reg) - 32'd1;
    assign at_terminal    = (count_reg == terminal_count);

    // State and datapath registers; reset overrides every request.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_reg       <= ST_RUN;
            count_reg       <= 32'd0;
            clock_out_reg   <= 1'b0;
            tick_reg        <= 1'b0;
            rate_sel_reg    <= 2'd0;
            pending_sel_reg <= 2'd0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            clock_out_reg   <= clock_out_next;
            tick_reg        <= tick_next;
            rate_sel_reg    <= rate_sel_next;
            pending_sel_reg <= pending_sel_next;
        end
    end

    // Next-state and datapath decisions, all judged against the state at
    // the start of the cycle (so next and pause together see the same state).
    always_comb begin
        logic [1:0] pending_inc;

        state_next       = state_reg;
        count_next       = count_reg;
        clock_out_next   = clock_out_reg;
        tick_next        = 1'b0;
        rate_sel_next    = rate_sel_reg;
        pending_sel_next = pending_sel_reg;
        pending_inc      = pending_sel_reg + 2'd1;

        case (state_reg)
            ST_RUN: begin
                // A next request only queues a rate; it is loaded at a toggle,
                // including a toggle in this very cycle.
                if (next_req) begin
                    pending_sel_next = pending_inc;
                end
                if (at_terminal) begin
                    // The toggle always completes, even if pause arrives now.
                    count_next     = 32'd0;
                    clock_out_next = ~clock_out_reg;
                    tick_next      = 1'b1;
                    rate_sel_next  = next_req ? pending_inc : pending_sel_reg;
                end else if (!pause_req) begin
                    count_next = count_reg + 32'd1;
                end
            end
            ST_PAUSE: begin
                // While paused a rate step is applied immediately and the
                // half-period restarts from zero on resume.
                if (next_req) begin
                    pending_sel_next = pending_inc;
                    rate_sel_next    = pending_inc;
                    count_next       = 32'd0;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        if (pause_req) begin
            state_next = (state_reg == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
    end

    assign clock_out = clock_out_reg;
    assign tick      = tick_reg;
    assign rate_sel  = rate_sel_reg;
    assign running   = (state_reg == ST_RUN);

endmodule

// File: tb/tb_blink_rate_sequencer.sv
// Self-checking bench for blink_rate_sequencer with short half-periods
// (4/6/8/10). Every cycle the expected output word from a behavioural model
// is queued when stimulus is driven and popped when the DUT output is sampled.
module tb_blink_rate_sequencer;

    localparam logic [31:0] H0 = 32'd4;
    localparam logic [31:0] H1 = 32'd6;
    localparam logic [31:0] H2 = 32'd8;
    localparam logic [31:0] H3 = 32'd10;

    logic       clock_in = 1'b0;
    logic       reset    = 1'b1;
    logic       next     = 1'b0;
    logic       pause    = 1'b0;
    logic       clock_out;
    logic       tick;
    logic [1:0] rate_sel;
    logic       running;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int unsigned m_count = 0;
    logic        m_clk   = 1'b0;
    logic        m_tick  = 1'b0;
    logic [1:0]  m_rate  = 2'd0;
    logic [1:0]  m_pend  = 2'd0;
    logic        m_run   = 1'b1;

    logic [4:0]  exp_q[$];

    blink_rate_sequencer #(
        .HALF0(H0),
        .HALF1(H1),
        .HALF2(H2),
        .HALF3(H3)
    ) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .next     (next),
        .pause    (pause),
        .clock_out(clock_out),
        .tick     (tick),
        .rate_sel (rate_sel),
        .running  (running)
    );

    always #5 clock_in = ~clock_in;

    function automatic int unsigned half_len(input logic [1:0] s);
        case (s)
            2'd0:    return H0;
            2'd1:    return H1;
            2'd2:    return H2;
            default: return H3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance the model by one clock edge from the specified behaviour.
    task automatic model_step(input logic n, input logic p, input logic r);
        logic [1:0] inc;
        if (r) begin
            m_count = 0; m_clk = 1'b0; m_tick = 1'b0;
            m_rate = 2'd0; m_pend = 2'd0; m_run = 1'b1;
        end else begin
            inc    = m_pend + 2'd1;
            m_tick = 1'b0;
            if (m_run) begin
                if (n) m_pend = inc;
                if (m_count == half_len(m_rate) - 1) begin
                    m_count = 0;
                    m_clk   = ~m_clk;
                    m_tick  = 1'b1;
                    m_rate  = m_pend;
                end else if (!p) begin
                    m_count = m_count + 1;
                end
            end else if (n) begin
                m_pend  = inc;
                m_rate  = inc;
                m_count = 0;
            end
            if (p) m_run = ~m_run;
        end
    endtask

    // One clock: drive, queue expectation, sample 1 time unit after the edge.
    task automatic cycle(input logic n, input logic p, input logic r);
        logic [4:0] expv;
        next  = n;
        pause = p;
        reset = r;
        model_step(n, p, r);
        exp_q.push_back({m_clk, m_tick, m_rate, m_run});
        @(posedge clock_in);
        #1;
        expv = exp_q.pop_front();
        check("outputs{clk,tick,rate,run}", {27'd0, clock_out, tick, rate_sel, running}, {27'd0, expv});
        next  = 1'b0;
        pause = 1'b0;
        reset = 1'b0;
    endtask

    // Idle until the DUT ticks; returns edges taken including the tick edge.
    task automatic run_until_tick(input int max_cycles, output int n);
        n = 0;
        do begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end while (!tick && n < max_cycles);
    endtask

    initial begin
        int n;
        #2;

        // Reset state.
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("reset_running", {31'd0, running}, 32'd1);
        $display("step reset: clock_out=%0b rate_sel=%0d running=%0b", clock_out, rate_sel, running);

        // Free-run at rate 0: toggle every 4 cycles.
        for (int i = 0; i < 3; i++) begin
            run_until_tick(20, n);
            check("rate0_half", n, 32'd4);
            $display("step rate0 half %0d: %0d cycles", i, n);
        end

        // One next pulse at cycle 1 of a half-period.
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("next_deferred", {30'd0, rate_sel}, 32'd0);
        run_until_tick(20, n);
        check("next_to_toggle", n, 32'd2);
        check("next_loaded", {30'd0, rate_sel}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            run_until_tick(20, n);
            check("rate1_half", n, 32'd6);
        end
        $display("step next in run: rate_sel=%0d half=%0d", rate_sel, n);

        // Four next pulses wrap pending back to rate 0.
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
        check("wrap_rate", {30'd0, rate_sel}, 32'd0);
        run_until_tick(20, n);
        check("wrap_half", n, 32'd4);
        $display("step four nexts: rate_sel=%0d half=%0d", rate_sel, n);

        // Pause at count 2, hold for 20 cycles, resume.
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("paused", {31'd0, running}, 32'd0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("resumed", {31'd0, running}, 32'd1);
        run_until_tick(20, n);
        check("resume_to_toggle", n, 32'd2);
        $display("step pause/resume: toggle %0d cycles after resume", n);

        // next while paused applies immediately and restarts the count.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("pause_next_rate", {30'd0, rate_sel}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0);
        run_until_tick(20, n);
        check("pause_next_half", n, 32'd6);
        $display("step next in pause: rate_sel=%0d first half=%0d", rate_sel, n);

        // Reset with count 3 and clock_out 1.
        n = 0;
        while (!(m_clk == 1'b1 && m_count == 3) && n < 40) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("mid_reset_setup", {31'd0, clock_out}, 32'd1);
        cycle(1'b0, 1'b0, 1'b1);
        check("mid_reset_clk", {31'd0, clock_out}, 32'd0);
        check("mid_reset_tick", {31'd0, tick}, 32'd0);
        $display("step mid reset: clock_out=%0b rate_sel=%0d running=%0b", clock_out, rate_sel, running);

        // next coincident with the toggle cycle loads at that same toggle.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("coincident_tick", {31'd0, tick}, 32'd1);
        check("coincident_rate", {30'd0, rate_sel}, 32'd1);
        run_until_tick(20, n);
        check("coincident_half", n, 32'd6);
        $display("step next at toggle: rate_sel=%0d half=%0d", rate_sel, n);

        // pause coincident with a toggle: toggle completes, then paused.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("pause_at_toggle_tick", {31'd0, tick}, 32'd1);
        check("pause_at_toggle_run", {31'd0, running}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("paused_no_tick", {31'd0, tick}, 32'd0);
        $display("step pause at toggle: running=%0b clock_out=%0b", running, clock_out);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
